// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream in and instruction memory write port of the boot loader
interface imem_boot_loader_if #(
  parameter int ADDR_W = 9
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - packs a length-prefixed byte stream into imem words and holds the core in reset until loaded
module imem_boot_loader #(
  parameter int ADDR_W      = 9,
  parameter int DEPTH_WORDS = 128,
  parameter int TIMEOUT     = 1000000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  imem_boot_loader_if.master   bus,
  output logic                 o_core_rst,
  output logic                 o_done,
  output logic                 o_error,
  output logic [7:0]           o_words_loaded
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN0  = 3'd1;
  localparam logic [2:0] LEN1  = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERROR = 3'd5;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]        r_state;
  logic [15:0]       r_len;
  logic [31:0]       r_asm;
  logic [1:0]        r_byte_cnt;
  logic [TW-1:0]     r_tmo;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [7:0]        r_words;

  logic        w_busy;
  logic        w_accept;
  logic [15:0] w_len;
  logic [31:0] w_word;

  assign w_busy   = (r_state == LEN0) || (r_state == LEN1) || (r_state == DATA);
  assign w_accept = w_busy && bus.byte_valid;
  assign w_len    = {bus.byte_data, r_len[7:0]};
  assign w_word   = {bus.byte_data, r_asm[31:8]};

  assign bus.byte_ready = w_busy;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign o_core_rst     = (r_state != DONE);
  assign o_done         = (r_state == DONE);
  assign o_error        = (r_state == ERROR);
  assign o_words_loaded = r_words;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_asm      <= '0;
      r_byte_cnt <= '0;
      r_tmo      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_words    <= '0;
    end else begin
      r_we <= 1'b0;

      // Idle-gap watchdog; placed first so a completing write below takes priority.
      if (w_busy) begin
        if (w_accept) begin
          r_tmo <= '0;
        end else if (r_tmo == TW'(TIMEOUT - 1)) begin
          r_state <= ERROR;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
      end

      case (r_state)
        IDLE, DONE, ERROR: begin
          if (i_start) begin
            r_state    <= LEN0;
            r_words    <= '0;
            r_byte_cnt <= '0;
            r_tmo      <= '0;
          end
        end
        LEN0: begin
          if (w_accept) begin
            r_len[7:0] <= bus.byte_data;
            r_state    <= LEN1;
          end
        end
        LEN1: begin
          if (w_accept) begin
            r_len[15:8] <= bus.byte_data;
            if (w_len == 16'd0) begin
              r_state <= DONE;
            end else if (w_len > 16'(DEPTH_WORDS)) begin
              r_state <= ERROR;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_accept) begin
            r_asm      <= w_word;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_we    <= 1'b1;
              r_wdata <= w_word;
              r_addr  <= ADDR_W'({r_words, 2'b00});
              r_words <= (r_words == 8'hFF) ? r_words : r_words + 8'd1;
            end
          end
          // r_words already counts the word being written this cycle.
          if (r_we && ({8'd0, r_words} == r_len)) begin
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder of the single-cycle core's instruction memory.
- Accepts a byte stream over a valid/ready handshake. Packs the bytes little-endian into 32-bit instruction words and writes them to instruction memory at consecutive word addresses.
- Holds the core in reset until a complete program is loaded.
- Sits between the serial receiver (UART RX byte interface) and the instruction memory write port / core reset.

Parameters:
- ADDR_W, 9: instruction memory byte-address width, matching the 9-bit PC.
- DEPTH_WORDS, 128: program capacity in words, equal to 2^ADDR_W/4.
- TIMEOUT, 1000000: maximum idle cycles between bytes in LEN0, LEN1 or DATA before ERROR.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; honoured in IDLE, DONE or ERROR only.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  byte address of the word being written (word_index*4).
- imem_wdata  out  32  instruction word.
- core_rst  out  1  reset to the processor datapath, active-high.
- done  out  1  high while in DONE.
- error  out  1  high while in ERROR.
- words_loaded  out  8  count of words written in the current or last load.

Behaviour:
- Reset values: state = IDLE, byte_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0, core_rst = 1, done = 0, error = 0, words_loaded = 0. All internal counters are cleared.
- Handshake: a byte is accepted on a rising edge where byte_valid && byte_ready.
  - byte_ready = 1 exactly in states LEN0, LEN1 and DATA. It is combinational from state.
  - byte_data must be held until the byte is accepted.
- Stream format: LEN low byte, then LEN high byte (16-bit word count N), then 4*N program bytes. Each word is sent LSB first: byte0 goes to [7:0] and byte3 to [31:24].
- IDLE: start moves to LEN0 and clears words_loaded, the byte counter and the timeout counter.
- LEN0: accept the low byte, go to LEN1.
- LEN1: accept the high byte and evaluate N:
  - N = 0 goes to DONE.
  - N > DEPTH_WORDS goes to ERROR.
  - Otherwise go to DATA.
- DATA: bytes shift into a 32-bit assembly register. On acceptance of the 4th byte of a word, the next cycle produces imem_we = 1 with:
  - imem_wdata = the assembled word;
  - imem_addr = words_loaded*4.
  - words_loaded increments in that same cycle.
  - After the write for word N-1, go to DONE. Total latency from the last byte accepted to the final imem_we is 1 cycle; DONE is entered on the edge after that write.
  - byte_ready stays 1 during the write cycle. A byte accepted in the write cycle belongs to the next word, so back-to-back bytes are permitted every cycle.
- DONE: core_rst = 0, done = 1. start returns to LEN0 with core_rst = 1 from the next cycle onward.
- ERROR: core_rst = 1, error = 1. The state is sticky until start (to LEN0) or rst.
- Timeout: in LEN0, LEN1 and DATA, a counter increments every cycle without an accepted byte and clears on acceptance. Reaching TIMEOUT goes to ERROR.
- core_rst = 1 in every state except DONE.
- start is ignored in LEN0, LEN1 and DATA.
- imem_we never asserts outside DATA write cycles.
- imem_addr wraps are impossible because N <= DEPTH_WORDS is enforced.
- words_loaded is 8 bits and saturates at 255. DEPTH_WORDS must be <= 255.
- rst mid-load: everything returns to reset values immediately. Words already written remain in memory. A partial word is discarded.
- Simultaneous start and rst: rst wins.

Test Plan:
- Reset, start, bytes 02 00 | 13 05 10 00 | 93 05 20 00 sent back-to-back → imem_we pulses carry (addr 0x000, data 0x00100513) and (addr 0x004, data 0x00200593). done=1 and core_rst=0 one cycle after the second write; words_loaded=2.
- Same stream with byte_valid toggled every other cycle → identical writes and data; no byte is lost or duplicated.
- Length bytes 81 00 (129 > 128) → error=1, core_rst=1, no imem_we. A following start returns to LEN0 with error=0.
- Length 00 00 → DONE two accepted bytes after start; no writes; core_rst=0.
- Length 01 00 followed by only 2 data bytes, TIMEOUT=16 → ERROR 16 cycles after the last byte; no imem_we; core_rst stays 1.
- rst asserted after 5 data bytes of a 2-word load → outputs return to reset values asynchronously. A fresh start then reloads the full program, with the first write at addr 0x000.
